// File: rtl/spi_flash_rd_seq.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_rd_seq
// Brief    : APB master that drives CoreSPI through a complete SPI-flash READ
//            (0x03) transfer and streams the returned bytes on a valid/ready
//            byte interface. Exactly one SPI frame is in flight at any time.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_rd_seq #(
  parameter logic [6:0] ADDR_TXDATA  = 7'h0C,
  parameter logic [6:0] ADDR_RXDATA  = 7'h08,
  parameter logic [6:0] ADDR_STAT    = 7'h20,
  parameter logic [6:0] ADDR_SSEL    = 7'h24,
  parameter int         STAT_RXEMPTY = 2,
  parameter int         STAT_TXFULL  = 3,
  parameter int         CNT_W        = 16
) (
  input  logic             PCLK,
  input  logic             PRESETN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [CNT_W-1:0] req_len,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [6:0]       M_PADDR,
  output logic             M_PSEL,
  output logic             M_PENABLE,
  output logic             M_PWRITE,
  output logic [31:0]      M_PWDATA,
  input  logic [31:0]      M_PRDATA,
  input  logic             M_PREADY,
  input  logic             M_PSLVERR
);

  localparam logic [7:0] c_CMD_READ   = 8'h03;
  // Frame index value from which received bytes are real read data.
  localparam logic [2:0] c_FRAME_DATA = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SS_ON   = 4'd1,
    S_TX_POLL = 4'd2,
    S_TX_WR   = 4'd3,
    S_RX_POLL = 4'd4,
    S_RX_RD   = 4'd5,
    S_OUT     = 4'd6,
    S_SS_OFF  = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } ph_t;

  state_t           r_state;
  state_t           w_state_nx;
  ph_t              r_ph;
  ph_t              w_ph_nx;

  logic [23:0]      r_addr;
  logic [CNT_W-1:0] r_rem;
  logic [2:0]       r_frame;
  logic [7:0]       r_rd_data;
  logic             r_err;

  logic             w_accept;
  logic             w_acc_done;
  logic             w_err_hit;
  logic             w_is_acc;
  logic [6:0]       w_paddr;
  logic             w_pwrite;
  logic [7:0]       w_wbyte;
  logic [7:0]       w_tx_byte;
  logic             w_apb_sel;
  wire logic        w_unused_prdata = ^M_PRDATA[31:8];

  assign req_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy       = !req_ready;
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign rd_valid   = (r_state == S_OUT);
  assign rd_data    = r_rd_data;

  assign w_accept   = req_valid && req_ready;
  assign w_acc_done = (r_ph == PH_ACCESS) && M_PREADY;
  assign w_err_hit  = w_acc_done && M_PSLVERR;

  // APB outputs come straight from registered state, so an async reset
  // drops PSEL immediately; address/data are zeroed outside an access.
  assign w_apb_sel  = (r_ph != PH_IDLE);
  assign M_PSEL     = w_apb_sel;
  assign M_PENABLE  = (r_ph == PH_ACCESS);
  assign M_PADDR    = w_apb_sel ? w_paddr : 7'd0;
  assign M_PWRITE   = w_apb_sel && w_pwrite;
  assign M_PWDATA   = w_apb_sel ? {24'd0, w_wbyte} : 32'd0;

  // Select the byte for the current frame: command, three address bytes, then dummies.
  always_comb begin
    w_tx_byte = 8'h00;
    case (r_frame)
      3'd0:    w_tx_byte = c_CMD_READ;
      3'd1:    w_tx_byte = r_addr[23:16];
      3'd2:    w_tx_byte = r_addr[15:8];
      3'd3:    w_tx_byte = r_addr[7:0];
      default: w_tx_byte = 8'h00;
    endcase
  end

  // Sequencer state and APB phase registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state <= S_IDLE;
      r_ph    <= PH_IDLE;
    end else begin
      r_state <= w_state_nx;
      r_ph    <= w_ph_nx;
    end
  end

  // Next-state, APB phase progression and per-state APB access parameters.
  always_comb begin
    w_state_nx = r_state;
    w_ph_nx    = r_ph;
    w_is_acc   = 1'b0;
    w_paddr    = 7'd0;
    w_pwrite   = 1'b0;
    w_wbyte    = 8'h00;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nx = (req_len == '0) ? S_DONE : S_SS_ON;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_SS_ON: begin
        w_is_acc = 1'b1;
        w_paddr  = ADDR_SSEL;
        w_pwrite = 1'b1;
        w_wbyte  = 8'h01;
        if (w_acc_done) begin
          w_state_nx = M_PSLVERR ? S_SS_OFF : S_TX_POLL;
        end
      end
      S_TX_POLL: begin
        w_is_acc = 1'b1;
        w_paddr  = ADDR_STAT;
        if (w_acc_done) begin
          if (M_PSLVERR)                 w_state_nx = S_SS_OFF;
          else if (M_PRDATA[STAT_TXFULL]) w_state_nx = S_TX_POLL;
          else                           w_state_nx = S_TX_WR;
        end
      end
      S_TX_WR: begin
        w_is_acc = 1'b1;
        w_paddr  = ADDR_TXDATA;
        w_pwrite = 1'b1;
        w_wbyte  = w_tx_byte;
        if (w_acc_done) begin
          w_state_nx = M_PSLVERR ? S_SS_OFF : S_RX_POLL;
        end
      end
      S_RX_POLL: begin
        w_is_acc = 1'b1;
        w_paddr  = ADDR_STAT;
        if (w_acc_done) begin
          if (M_PSLVERR)                  w_state_nx = S_SS_OFF;
          else if (M_PRDATA[STAT_RXEMPTY]) w_state_nx = S_RX_POLL;
          else                            w_state_nx = S_RX_RD;
        end
      end
      S_RX_RD: begin
        w_is_acc = 1'b1;
        w_paddr  = ADDR_RXDATA;
        if (w_acc_done) begin
          if (M_PSLVERR)                     w_state_nx = S_SS_OFF;
          else if (r_frame != c_FRAME_DATA)  w_state_nx = S_TX_POLL;
          else                               w_state_nx = S_OUT;
        end
      end
      S_OUT: begin
        // Next frame is not launched until the consumer takes this byte.
        if (rd_ready) begin
          w_state_nx = (r_rem == CNT_W'(1)) ? S_SS_OFF : S_TX_POLL;
        end
      end
      S_SS_OFF: begin
        w_is_acc = 1'b1;
        w_paddr  = ADDR_SSEL;
        w_pwrite = 1'b1;
        w_wbyte  = 8'h00;
        // Slave-select release is best effort: its own error is not acted on.
        if (w_acc_done) begin
          w_state_nx = S_DONE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    if (w_is_acc) begin
      case (r_ph)
        PH_IDLE:   w_ph_nx = PH_SETUP;
        PH_SETUP:  w_ph_nx = PH_ACCESS;
        PH_ACCESS: if (M_PREADY) w_ph_nx = PH_IDLE;
        default:   w_ph_nx = PH_IDLE;
      endcase
    end
  end

  // Request latch, byte/frame counters, captured read byte and sticky error.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_addr    <= 24'd0;
      r_rem     <= '0;
      r_frame   <= 3'd0;
      r_rd_data <= 8'h00;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_rem   <= req_len;
        r_frame <= 3'd0;
        r_err   <= 1'b0;
      end
      if (w_err_hit && (r_state != S_SS_OFF)) begin
        r_err <= 1'b1;
      end
      if ((r_state == S_RX_RD) && w_acc_done && !M_PSLVERR) begin
        if (r_frame != c_FRAME_DATA) begin
          r_frame <= r_frame + 3'd1;
        end else begin
          r_rd_data <= M_PRDATA[7:0];
        end
      end
      if ((r_state == S_OUT) && rd_ready) begin
        r_rem <= r_rem - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_rd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_rd_seq
// Brief    : Self-checking bench for spi_flash_rd_seq with an APB CoreSPI
//            slave model, expected-access and expected-byte scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_rd_seq;

  localparam int         CNT_W = 16;
  localparam logic [6:0] A_TX  = 7'h0C;
  localparam logic [6:0] A_RX  = 7'h08;
  localparam logic [6:0] A_ST  = 7'h20;
  localparam logic [6:0] A_SS  = 7'h24;

  logic             PCLK      = 1'b0;
  logic             PRESETN   = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [23:0]      req_addr  = 24'd0;
  logic [CNT_W-1:0] req_len   = '0;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready  = 1'b1;
  logic             busy;
  logic             done;
  logic             err;
  logic [6:0]       M_PADDR;
  logic             M_PSEL;
  logic             M_PENABLE;
  logic             M_PWRITE;
  logic [31:0]      M_PWDATA;
  logic [31:0]      M_PRDATA  = 32'd0;
  logic             M_PREADY  = 1'b0;
  logic             M_PSLVERR = 1'b0;

  spi_flash_rd_seq dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err),
    .M_PADDR(M_PADDR), .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .M_PSLVERR(M_PSLVERR)
  );

  // 100 MHz clock.
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [23:0] addr;
    int          len;
    int          tf;     // STAT polls reporting TXFULL before each TX write
    int          re;     // STAT polls reporting RXEMPTY before each RX read
    int          wt;     // PREADY wait cycles per access
    int          errwr;  // 1-based TXDATA write that gets PSLVERR (0 = none)
    int          stall;  // cycles rd_ready is held low on the first data byte
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic       w;
    logic [6:0] a;
    logic [7:0] d;
  } apb_t;

  apb_t       exp_apb[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rxq[$];

  int n_total = 0;
  int n_bad   = 0;
  int cfg_tf = 0, cfg_re = 0, cfg_wt = 0, cfg_errwr = 0, stall_left = 0;
  int txc = 0, rxc = 0, txwr_n = 0, wcnt = 0, done_cnt = 0;
  bit in_rx = 1'b0, prev_done = 1'b0, s_valid = 1'b0;
  logic [6:0]  s_a;
  logic        s_w;
  logic [31:0] s_d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Build the expected APB access list, slave RX contents and output bytes.
  task automatic setup(input vec_t v);
    apb_t e;
    bit   stop;
    cfg_tf = v.tf; cfg_re = v.re; cfg_wt = v.wt; cfg_errwr = v.errwr;
    stall_left = v.stall;
    txc = 0; rxc = 0; txwr_n = 0; in_rx = 1'b0;
    exp_apb.delete(); exp_rd.delete(); rxq.delete();
    if (v.len == 0) return;
    e = '{1'b1, A_SS, 8'h01}; exp_apb.push_back(e);
    stop = 1'b0;
    for (int f = 0; f < 4 + v.len && !stop; f++) begin
      logic [7:0] b;
      logic [7:0] rx;
      b = (f == 0) ? 8'h03 : (f == 1) ? v.addr[23:16] : (f == 2) ? v.addr[15:8] :
          (f == 3) ? v.addr[7:0] : 8'h00;
      for (int p = 0; p <= v.tf; p++) begin e = '{1'b0, A_ST, 8'h00}; exp_apb.push_back(e); end
      e = '{1'b1, A_TX, b}; exp_apb.push_back(e);
      if (f + 1 == v.errwr) begin
        stop = 1'b1;
      end else begin
        for (int p = 0; p <= v.re; p++) begin e = '{1'b0, A_ST, 8'h00}; exp_apb.push_back(e); end
        e = '{1'b0, A_RX, 8'h00}; exp_apb.push_back(e);
        rx = (f < 4) ? 8'hFF : (f == 4) ? v.d0 : (f == 5) ? v.d1 : 8'($urandom_range(0, 255));
        rxq.push_back(rx);
        if (f >= 4) exp_rd.push_back(rx);
      end
    end
    e = '{1'b0, A_SS, 8'h00}; e.w = 1'b1; exp_apb.push_back(e);
  endtask

  // Score a completing APB access and produce the CoreSPI response for it.
  task automatic apb_complete();
    apb_t e;
    if (exp_apb.size() == 0) begin
      n_total++; n_bad++;
      $display("FAIL apb_extra: got addr %0h write %0b, want no access", M_PADDR, M_PWRITE);
    end else begin
      e = exp_apb.pop_front();
      chk("apb_addr", M_PADDR, e.a);
      chk("apb_write", M_PWRITE, e.w);
      if (e.w) chk("apb_wdata", M_PWDATA, {24'h0, e.d});
    end
    if (M_PWRITE && M_PADDR == A_TX) begin
      txwr_n++;
      if (txwr_n == cfg_errwr) M_PSLVERR = 1'b1;
      else in_rx = 1'b1;
    end else if (!M_PWRITE && M_PADDR == A_ST) begin
      if (!in_rx) begin
        if (txc < cfg_tf) begin M_PRDATA = 32'h8; txc++; end else txc = 0;
      end else begin
        if (rxc < cfg_re) begin M_PRDATA = 32'h4; rxc++; end else rxc = 0;
      end
    end else if (!M_PWRITE && M_PADDR == A_RX) begin
      logic [7:0] b;
      b = 8'h00;
      if (rxq.size() > 0) b = rxq.pop_front();
      M_PRDATA = {24'hABCDEF, b};
      in_rx = 1'b0;
    end
  endtask

  // APB slave model and protocol monitor, driven on the falling edge.
  always @(negedge PCLK) begin
    if (!PRESETN) begin
      M_PREADY = 1'b0; M_PSLVERR = 1'b0; M_PRDATA = 32'd0;
      prev_done = 1'b0; s_valid = 1'b0; wcnt = 0;
    end else begin
      if (prev_done) chk("apb_psel_drop", M_PSEL, 1'b0);
      prev_done = 1'b0;
      M_PREADY = 1'b0; M_PSLVERR = 1'b0; M_PRDATA = 32'd0;
      if (M_PSEL && !M_PENABLE) begin
        s_a = M_PADDR; s_w = M_PWRITE; s_d = M_PWDATA; s_valid = 1'b1; wcnt = 0;
      end else if (M_PSEL && M_PENABLE) begin
        chk("apb_setup_seen", s_valid, 1'b1);
        chk("apb_stable", {M_PADDR, M_PWRITE, M_PWDATA}, {s_a, s_w, s_d});
        if (wcnt >= cfg_wt) begin
          M_PREADY = 1'b1;
          apb_complete();
          prev_done = 1'b1;
          s_valid = 1'b0;
        end else begin
          wcnt++;
        end
      end
      if (rd_valid) chk("apb_quiet_in_out", M_PSEL, 1'b0);
    end
  end

  // Byte consumer with optional backpressure on the first data byte.
  always @(negedge PCLK) begin
    if (!PRESETN) begin
      rd_ready = 1'b1;
    end else if (rd_valid) begin
      if (exp_rd.size() == 0) begin
        n_total++; n_bad++;
        $display("FAIL rd_extra: got %0h want no byte", rd_data);
        rd_ready = 1'b1;
      end else if (stall_left > 0) begin
        rd_ready = 1'b0;
        stall_left--;
        chk("rd_hold", rd_data, exp_rd[0]);
      end else begin
        rd_ready = 1'b1;
        chk("rd_data", rd_data, exp_rd.pop_front());
      end
    end
  end

  // Count done pulses.
  always @(negedge PCLK) begin
    if (PRESETN && done) done_cnt++;
  end

  task automatic chk_reset_outs();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_psel", M_PSEL, 1'b0);
    chk("rst_penable", M_PENABLE, 1'b0);
    chk("rst_paddr", M_PADDR, 7'd0);
    chk("rst_pwrite", M_PWRITE, 1'b0);
    chk("rst_pwdata", M_PWDATA, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int d0;
    bit seen;
    setup(v);
    @(negedge PCLK);
    chk("req_ready_idle", req_ready, 1'b1);
    chk("busy_idle", busy, 1'b0);
    d0 = done_cnt;
    req_valid = 1'b1; req_addr = v.addr; req_len = CNT_W'(v.len);
    @(negedge PCLK);
    chk("err_clear", err, 1'b0);
    if (v.len == 0) begin
      chk("len0_done", done, 1'b1);
      chk("len0_busy", busy, 1'b0);
      req_valid = 1'b0;
    end else begin
      chk("busy_on", busy, 1'b1);
      req_addr = 24'hDEAD00; req_len = CNT_W'(1);
      repeat (3) begin
        @(negedge PCLK);
        chk("req_ready_busy", req_ready, 1'b0);
      end
      req_valid = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      if (done_cnt != d0) seen = 1'b1;
      else @(negedge PCLK);
    end
    chk("done_seen", seen, 1'b1);
    repeat (3) @(negedge PCLK);
    chk("done_pulses", done_cnt - d0, 1);
    chk("err_final", err, v.exp_err);
    chk("apb_left", exp_apb.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
  endtask

  initial begin
    vec_t vt[8];
    vec_t vr;
    bit   seen;
    vt[0] = '{24'h012345, 2, 0, 0, 0, 0, 0,  8'hA5, 8'h5A, 1'b0};
    vt[1] = '{24'hABCDEF, 1, 3, 5, 0, 0, 0,  8'hC3, 8'h00, 1'b0};
    vt[2] = '{24'h000001, 2, 0, 0, 0, 0, 10, 8'h3C, 8'h96, 1'b0};
    vt[3] = '{24'h012345, 2, 0, 0, 4, 0, 0,  8'hA5, 8'h5A, 1'b0};
    vt[4] = '{24'h7FFFFF, 3, 0, 0, 0, 2, 0,  8'h11, 8'h22, 1'b1};
    vt[5] = '{24'h123456, 0, 0, 0, 0, 0, 0,  8'h00, 8'h00, 1'b0};
    vt[6] = '{24'hFEDCBA, 4, 1, 2, 1, 0, 2,  8'hE7, 8'h18, 1'b0};
    vt[7] = '{24'h800000, 1, 0, 0, 2, 5, 0,  8'h42, 8'h00, 1'b1};

    PRESETN = 1'b0;
    repeat (3) @(negedge PCLK);
    chk_reset_outs();
    PRESETN = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Reset while a data byte is being offered.
    vr = '{24'h111111, 3, 0, 0, 0, 0, 1000, 8'h11, 8'h22, 1'b0};
    setup(vr);
    @(negedge PCLK);
    req_valid = 1'b1; req_addr = vr.addr; req_len = CNT_W'(3);
    @(negedge PCLK);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      if (rd_valid) seen = 1'b1;
      else @(negedge PCLK);
    end
    chk("out_reached", seen, 1'b1);
    @(negedge PCLK);
    #2 PRESETN = 1'b0;
    #1 chk_reset_outs();
    exp_apb.delete(); exp_rd.delete(); rxq.delete(); stall_left = 0;
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    run_vec(vt[0]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
